pda_char_feeder: RTL

- Upstream stage of the pattern-matching pushdown automaton.
- Accepts byte strings from a host over a valid/ready stream with an end-of-string marker (s_last), buffers them in a FIFO, and replays each complete string back-to-back, one character per clock, on out_char.
- After every string it emits SEP_CYCLES separator characters. These force the matcher out of its final-term state so it evaluates and clears its counters.
- The matcher has no stall or valid input, so a string is never started until it is completely buffered (store-and-forward). This guarantees gap-free delivery.

---
 rtl/pda_char_feeder.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/pda_char_feeder.sv
// Store-and-forward character feeder for the pattern-matching PDA.
// Buffers host strings and replays each complete one gap-free, followed by separators.
module pda_char_feeder #(
    parameter int         DEPTH      = 16,
    parameter logic [7:0] SEP_CHAR   = 8'h00,
    parameter int         SEP_CYCLES = 2,
    parameter int         CNT_W      = 16
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [7:0]                s_data,
    input  logic                      s_valid,
    input  logic                      s_last,
    output logic                      s_ready,
    output logic [7:0]                out_char,
    output logic                      out_valid,
    output logic                      out_eos,
    output logic [CNT_W-1:0]          str_count,
    output logic [$clog2(DEPTH):0]    fifo_level,
    output logic                      overflow_err
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam int SW = $clog2(SEP_CYCLES) + 1;

    typedef enum logic {W_ACCEPT, W_DISCARD} wstate_t;
    typedef enum logic [1:0] {R_IDLE, R_SEND, R_SEP} rstate_t;

    wstate_t wstate, wstate_nxt;
    rstate_t rstate, rstate_nxt;

    logic [8:0]    mem [DEPTH];
    logic [8:0]    head;
    logic [LW-1:0] wr_ptr, rd_ptr, str_start, complete_cnt;
    logic [SW-1:0] sep_cnt, sep_cnt_nxt;
    logic          out_last;
    logic          push, pop, rewind, done, inc;
    logic [7:0]    out_char_nxt;
    logic          out_valid_nxt, out_eos_nxt;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign fifo_level = wr_ptr - rd_ptr;
    assign head       = mem[rd_ptr[AW-1:0]];
    assign inc        = push & s_last;

    always_comb begin
        wstate_nxt = wstate;
        s_ready    = 1'b0;
        push       = 1'b0;
        rewind     = 1'b0;
        case (wstate)
            W_ACCEPT: begin
                s_ready = (fifo_level < LW'(DEPTH));
                push    = s_valid & s_ready;
                // Full with no complete string: this partial string can never finish.
                if (fifo_level == LW'(DEPTH) && complete_cnt == '0) begin
                    rewind     = 1'b1;
                    wstate_nxt = W_DISCARD;
                end
            end
            W_DISCARD: begin
                s_ready = 1'b1;
                if (s_valid && s_last) wstate_nxt = W_ACCEPT;
            end
            default: wstate_nxt = W_ACCEPT;
        endcase
    end

    always_comb begin
        rstate_nxt    = rstate;
        pop           = 1'b0;
        done          = 1'b0;
        sep_cnt_nxt   = sep_cnt;
        out_char_nxt  = out_char;
        out_valid_nxt = out_valid;
        out_eos_nxt   = 1'b0;
        case (rstate)
            R_IDLE: begin
                out_char_nxt  = SEP_CHAR;
                out_valid_nxt = 1'b0;
                if (complete_cnt != '0) begin
                    pop        = 1'b1;
                    rstate_nxt = R_SEND;
                end
            end
            R_SEND: begin
                if (out_last) begin
                    done          = 1'b1;
                    out_char_nxt  = SEP_CHAR;
                    out_valid_nxt = 1'b0;
                    out_eos_nxt   = 1'b1;
                    sep_cnt_nxt   = SW'(1);
                    rstate_nxt    = R_SEP;
                end else begin
                    pop = 1'b1;
                end
            end
            R_SEP: begin
                out_char_nxt  = SEP_CHAR;
                out_valid_nxt = 1'b0;
                if (sep_cnt == SW'(SEP_CYCLES - 1)) rstate_nxt = R_IDLE;
                else sep_cnt_nxt = sep_cnt + 1'b1;
            end
            default: rstate_nxt = R_IDLE;
        endcase
        if (pop) begin
            out_char_nxt  = head[7:0];
            out_valid_nxt = 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (push) mem[wr_ptr[AW-1:0]] <= {s_last, s_data};
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wstate       <= W_ACCEPT;
            rstate       <= R_IDLE;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            str_start    <= '0;
            complete_cnt <= '0;
            sep_cnt      <= '0;
            out_last     <= 1'b0;
            out_char     <= SEP_CHAR;
            out_valid    <= 1'b0;
            out_eos      <= 1'b0;
            str_count    <= '0;
            overflow_err <= 1'b0;
        end else begin
            wstate    <= wstate_nxt;
            rstate    <= rstate_nxt;
            sep_cnt   <= sep_cnt_nxt;
            out_char  <= out_char_nxt;
            out_valid <= out_valid_nxt;
            out_eos   <= out_eos_nxt;
            if (rewind) wr_ptr <= str_start;
            else if (push) wr_ptr <= wr_ptr + 1'b1;
            if (inc) str_start <= wr_ptr + 1'b1;
            if (rewind) overflow_err <= 1'b1;
            if (pop) begin
                rd_ptr   <= rd_ptr + 1'b1;
                out_last <= head[8];
            end
            complete_cnt <= complete_cnt + LW'(inc) - LW'(done);
            if (done) str_count <= str_count + 1'b1;
        end
    end
endmodule
